seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Consumer-side counterpart of the free-running up-counter: receives a sampled count stream and checks that it increments by exactly 1 per valid sample, modulo 2^WIDTH.
- Acquires lock after LOCK_COUNT consecutive correct increments.
- Flags every break in sequence and keeps a saturating error tally.
- Sits in the testbench/sim fabric next to the sequence-stream plumbing, or in hardware behind any counter source.

Parameters:
- WIDTH, 8, data width of the checked count.
- ERR_WIDTH, 16, width of the saturating error counter.
- LOCK_COUNT, 4, consecutive in-sequence samples (including the first) needed to declare lock; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; all state cleared while low.
- in_valid  input  1  in_data is a sample this cycle.
- in_data  input  WIDTH  sampled count value.
- clr  input  1  synchronous clear of err_count (and capture registers if built).
- locked  output  1  registered; 1 while in LOCKED state.
- mismatch  output  1  registered one-cycle pulse per detected sequence break.
- err_count  output  ERR_WIDTH  registered count of breaks; saturates at all-ones.
- expected  output  WIDTH  registered next expected value.

Behaviour:
- Reset (rst==0, async): state=SEARCH, run=0, expected=0, locked=0, mismatch=0, err_count=0.
- in_valid==0: no state change; mismatch returns to 0.
- All outputs update on the rising edge after the sample. Latency from sample to locked/mismatch/err_count is 1 cycle.
- SEARCH, run==0, valid sample: expected<=in_data+1 (wraps), run<=1.
- SEARCH, run>0, valid sample, in_data==expected:
  - expected<=expected+1, run<=run+1.
  - If run+1==LOCK_COUNT: state<=LOCKED, locked<=1, run<=0.
- SEARCH, run>0, valid sample, mismatch: expected<=in_data+1, run<=1.
  - No mismatch pulse; errors are counted only once locked.
- LOCKED, match: expected<=expected+1; locked stays 1.
- LOCKED, mismatch:
  - mismatch<=1 for one cycle; err_count+1, saturating.
  - state<=SEARCH, locked<=0, expected<=in_data+1, run<=1.
  - The bad sample seeds re-acquisition.
- Wrap: all-ones followed by 0 is in-sequence (modulo arithmetic, WIDTH bits, carry discarded).
- Saturation: err_count held at 2^ERR_WIDTH-1; further breaks still pulse mismatch.
- clr:
  - clr alone: err_count<=0.
  - clr with a simultaneous LOCKED mismatch: err_count<=1.
  - clr does not affect state, expected or locked.
- Reset asserted mid-stream: immediate return to reset values; first valid sample after release is treated as run==0.

Optional Feature:
- Macro: SEQ_CHECKER_CAPTURE_EN.
- Defined:
  - Adds outputs cap_valid (1), cap_exp (WIDTH), cap_got (WIDTH).
  - On the first LOCKED mismatch after reset or clr: cap_exp<=expected, cap_got<=in_data, cap_valid<=1.
  - Later mismatches do not overwrite the capture.
  - Reset and clr zero all three.
  - clr coincident with a mismatch: capture that mismatch, cap_valid=1.
- Undefined: the three ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then feed 10,11,12,13 with in_valid every cycle -> locked=1 on the edge after 13; expected=14; err_count=0; mismatch never 1.
- Locked at expected=20, feed 25 -> mismatch=1 for exactly one cycle, err_count=1, locked=0, expected=26. Then feed 26,27,28 -> locked=1 again after 28.
- Lock on 253,254,255,0, then feed 1 -> no mismatch, locked=1, expected=2 (wrap check).
- Unlocked, feed 5,9,10,11,12 -> no mismatch pulses, err_count=0; locked=1 after 12. in_valid=0 gaps between samples change nothing.
- ERR_WIDTH=2: force 5 locked breaks (relock between each) -> err_count=3 after break 3 and stays 3; mismatch pulses 5 times. clr together with a 6th break -> err_count=1.
- CAPTURE_EN: locked at expected=40, feed 7 then relock and break again -> cap_exp=40, cap_got=7, cap_valid=1, unchanged by the second break. Assert rst mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/seq_checker.sv
// Sequence checker: locks onto a +1-per-sample count stream and tallies breaks once locked.
// Optional mismatch capture registers are built when SEQ_CHECKER_CAPTURE_EN is defined.
module seq_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ERR_WIDTH  = 16,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 clr,
    output logic                 locked,
    output logic                 mismatch,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     expected
`ifdef SEQ_CHECKER_CAPTURE_EN
    ,
    output logic                 cap_valid,
    output logic [WIDTH-1:0]     cap_exp,
    output logic [WIDTH-1:0]     cap_got
`endif
);

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_e;

    state_e                 state_q;
    logic [7:0]             run_q;
    logic [7:0]             run_inc;
    logic [WIDTH-1:0]       expected_q;
    logic [WIDTH-1:0]       seed;
    logic                   locked_q;
    logic                   mismatch_q;
    logic [ERR_WIDTH-1:0]   err_q;
    logic [ERR_WIDTH-1:0]   err_d;
    logic                   hit;
    logic                   brk;

    assign hit     = in_valid && (in_data == expected_q);
    assign brk     = in_valid && (state_q == LOCKED) && (in_data != expected_q);
    assign seed    = in_data + WIDTH'(1);
    assign run_inc = run_q + 8'd1;

    // A break coinciding with clr is the first error of the fresh tally.
    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = brk ? ERR_WIDTH'(1) : '0;
        end else if (brk && (err_q != '1)) begin
            err_d = err_q + ERR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEARCH;
            run_q      <= '0;
            expected_q <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            mismatch_q <= 1'b0;
            err_q      <= err_d;
            if (in_valid) begin
                case (state_q)
                    SEARCH: begin
                        if ((run_q == '0) || !hit) begin
                            expected_q <= seed;
                            run_q      <= 8'd1;
                        end else begin
                            expected_q <= expected_q + WIDTH'(1);
                            if (run_inc == 8'(LOCK_COUNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                run_q    <= '0;
                            end else begin
                                run_q <= run_inc;
                            end
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            expected_q <= expected_q + WIDTH'(1);
                        end else begin
                            // The offending sample seeds re-acquisition.
                            mismatch_q <= 1'b1;
                            state_q    <= SEARCH;
                            locked_q   <= 1'b0;
                            expected_q <= seed;
                            run_q      <= 8'd1;
                        end
                    end
                    default: begin
                        state_q <= SEARCH;
                        run_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;
    assign expected  = expected_q;

`ifdef SEQ_CHECKER_CAPTURE_EN
    logic             cap_valid_q;
    logic [WIDTH-1:0] cap_exp_q;
    logic [WIDTH-1:0] cap_got_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_valid_q <= 1'b0;
            cap_exp_q   <= '0;
            cap_got_q   <= '0;
        end else if (brk && (clr || !cap_valid_q)) begin
            cap_valid_q <= 1'b1;
            cap_exp_q   <= expected_q;
            cap_got_q   <= in_data;
        end else if (clr) begin
            cap_valid_q <= 1'b0;
            cap_exp_q   <= '0;
            cap_got_q   <= '0;
        end
    end

    assign cap_valid = cap_valid_q;
    assign cap_exp   = cap_exp_q;
    assign cap_got   = cap_got_q;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed vector table, saturation/capture sequences,
// and random stimulus against a streak-based reference model.
module tb_seq_checker;

    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        clr = 1'b0;
    logic        locked, mismatch, locked_s, mismatch_s;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;
    logic [7:0]  expected, expected_s;
`ifdef SEQ_CHECKER_CAPTURE_EN
    logic        cap_valid, cap_valid_s;
    logic [7:0]  cap_exp, cap_got, cap_exp_s, cap_got_s;
`endif

    always #5 clk = ~clk;

    seq_checker #(.WIDTH(8), .ERR_WIDTH(16), .LOCK_COUNT(LOCK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(locked), .mismatch(mismatch), .err_count(err_count), .expected(expected)
`ifdef SEQ_CHECKER_CAPTURE_EN
        , .cap_valid(cap_valid), .cap_exp(cap_exp), .cap_got(cap_got)
`endif
    );

    seq_checker #(.WIDTH(8), .ERR_WIDTH(2), .LOCK_COUNT(LOCK)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(locked_s), .mismatch(mismatch_s), .err_count(err_count_s), .expected(expected_s)
`ifdef SEQ_CHECKER_CAPTURE_EN
        , .cap_valid(cap_valid_s), .cap_exp(cap_exp_s), .cap_got(cap_got_s)
`endif
    );

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    // Reference model: streak of consecutive in-sequence samples and the value that must come next.
    bit m_locked, m_mism, m_capv;
    int m_next, m_streak, m_err, m_err_s, m_cape, m_capg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d want %0d", nm, act, exp);
        else passed++;
    endtask

    task automatic model_reset();
        m_locked = 0; m_mism = 0; m_capv = 0;
        m_next = 0; m_streak = 0; m_err = 0; m_err_s = 0; m_cape = 0; m_capg = 0;
    endtask

    task automatic model_update(input bit v, input int d, input bit c);
        int  prev;
        bit  in_seq;
        prev   = m_next;
        in_seq = v && (d == m_next);
        m_mism = 0;
        if (v) begin
            if (m_locked) begin
                if (in_seq) m_next = (m_next + 1) % 256;
                else begin
                    m_mism = 1; m_locked = 0; m_next = (d + 1) % 256; m_streak = 1;
                end
            end else if (m_streak > 0 && in_seq) begin
                m_next = (m_next + 1) % 256;
                m_streak++;
                if (m_streak == LOCK) begin m_locked = 1; m_streak = 0; end
            end else begin
                m_next = (d + 1) % 256; m_streak = 1;
            end
        end
        if (c) begin
            m_err = m_mism; m_err_s = m_mism;
        end else if (m_mism) begin
            m_err   = (m_err < 65535) ? m_err + 1 : 65535;
            m_err_s = (m_err_s < 3) ? m_err_s + 1 : 3;
        end
        if (m_mism && (c || !m_capv)) begin
            m_capv = 1; m_cape = prev; m_capg = d;
        end else if (c) begin
            m_capv = 0; m_cape = 0; m_capg = 0;
        end
    endtask

    task automatic step(input bit v, input int d, input bit c);
        in_valid = v; in_data = 8'(d); clr = c;
        @(posedge clk); #1;
        model_update(v, d & 255, c);
        if (mismatch) pulses++;
        chk("locked", locked, m_locked);
        chk("mismatch", mismatch, m_mism);
        chk("err_count", err_count, m_err);
        chk("expected", expected, m_next);
        chk("err_count_w2", err_count_s, m_err_s);
        chk("mismatch_w2", mismatch_s, m_mism);
`ifdef SEQ_CHECKER_CAPTURE_EN
        chk("cap_valid", cap_valid, m_capv);
        chk("cap_exp", cap_exp, m_cape);
        chk("cap_got", cap_got, m_capg);
`endif
        in_valid = 0; clr = 0;
    endtask

    task automatic do_break(input bit c);
        int bad;
        bad = (m_next + 77) % 256;
        step(1, bad, c);
        for (int j = 1; j <= 3; j++) step(1, (bad + j) % 256, 0);
    endtask

    typedef struct {
        bit v; int d; bit c;
        bit l; bit m; int e; int x;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit v, int d, bit c, bit l, bit m, int e, int x);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.l = l; r.m = m; r.e = e; r.x = x;
        tbl.push_back(r);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        add(1, 10, 0, 0, 0, 0, 11); add(1, 11, 0, 0, 0, 0, 12);
        add(1, 12, 0, 0, 0, 0, 13); add(1, 13, 0, 1, 0, 0, 14);
        for (int d = 14; d < 20; d++) add(1, d, 0, 1, 0, 0, d + 1);
        add(1, 25, 0, 0, 1, 1, 26); add(0, 0, 0, 0, 0, 1, 26);
        add(1, 26, 0, 0, 0, 1, 27); add(1, 27, 0, 0, 0, 1, 28);
        add(1, 28, 0, 1, 0, 1, 29);
        add(1, 253, 0, 0, 1, 2, 254); add(1, 254, 0, 0, 0, 2, 255);
        add(1, 255, 0, 0, 0, 2, 0);   add(1, 0, 0, 1, 0, 2, 1);
        add(1, 1, 0, 1, 0, 2, 2);
        add(1, 5, 0, 0, 1, 3, 6);
        add(1, 9, 0, 0, 0, 3, 10);  add(0, 0, 0, 0, 0, 3, 10);
        add(1, 10, 0, 0, 0, 3, 11); add(0, 0, 0, 0, 0, 3, 11);
        add(1, 11, 0, 0, 0, 3, 12); add(0, 0, 0, 0, 0, 3, 12);
        add(1, 12, 0, 1, 0, 3, 13);
        add(0, 0, 1, 1, 0, 0, 13);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_err", err_count, 0);
        chk("rst_expected", expected, 0);
        rst = 1;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk("tbl_locked", locked, tbl[i].l);
            chk("tbl_mismatch", mismatch, tbl[i].m);
            chk("tbl_err", err_count, tbl[i].e);
            chk("tbl_expected", expected, tbl[i].x);
        end

        for (int d = 13; d < 40; d++) step(1, d, 0);
        step(1, 7, 0);
        chk("cap_brk_mismatch", mismatch, 1);
        chk("cap_brk_err", err_count, 1);
        chk("cap_brk_expected", expected, 8);
`ifdef SEQ_CHECKER_CAPTURE_EN
        chk("cap1_valid", cap_valid, 1);
        chk("cap1_exp", cap_exp, 40);
        chk("cap1_got", cap_got, 7);
`endif
        step(1, 8, 0); step(1, 9, 0); step(1, 10, 0);
        chk("relock", locked, 1);
        step(1, 100, 0);
        chk("second_brk_err", err_count, 2);
`ifdef SEQ_CHECKER_CAPTURE_EN
        chk("cap_hold_exp", cap_exp, 40);
        chk("cap_hold_got", cap_got, 7);
`endif
        step(0, 0, 1);
        chk("clr_err", err_count, 0);
        step(1, 101, 0); step(1, 102, 0); step(1, 103, 0);
        chk("relock2", locked, 1);

        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            do_break(0);
            chk("sat_err_w2", err_count_s, (k < 3) ? k : 3);
            chk("sat_err_w16", err_count, k);
        end
        chk("sat_pulses", pulses, 5);
        do_break(1);
        chk("clr_brk_err_w2", err_count_s, 1);
        chk("clr_brk_err_w16", err_count, 1);

        for (int n = 0; n < 3000; n++) begin
            bit v, c;
            int d;
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) < 7) ? m_next : int'($urandom_range(0, 255));
            c = ($urandom_range(0, 39) == 0);
            step(v, d, c);
        end

        for (int j = 0; j < 5; j++) step(1, m_next, 0);
        @(posedge clk);
        #3 rst = 0;
        #1;
        chk("async_locked", locked, 0);
        chk("async_mismatch", mismatch, 0);
        chk("async_err", err_count, 0);
        chk("async_expected", expected, 0);
        chk("async_err_w2", err_count_s, 0);
`ifdef SEQ_CHECKER_CAPTURE_EN
        chk("async_cap_valid", cap_valid, 0);
        chk("async_cap_exp", cap_exp, 0);
        chk("async_cap_got", cap_got, 0);
`endif
        model_reset();
        @(posedge clk);
        #1 rst = 1;
        step(1, 50, 0);
        chk("post_rst_expected", expected, 51);
        chk("post_rst_locked", locked, 0);
        step(1, 51, 0); step(1, 52, 0); step(1, 53, 0);
        chk("post_rst_lock", locked, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
